// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for the EX stage: one quotient bit per cycle,
// signed operands handled by magnitude division plus a final sign correction.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 div_valid,
    input  logic                 signed_div,
    input  logic [WIDTH-1:0]     opdata1,
    input  logic [WIDTH-1:0]     opdata2,
    input  logic                 annul,
    output logic [2*WIDTH-1:0]   result,
    output logic                 ready,
    output logic                 stall_div
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_DIVZERO = 2'd1;
    localparam logic [1:0] ST_ON      = 2'd2;
    localparam logic [1:0] ST_END     = 2'd3;

    logic [1:0]         state_q,  state_d;
    logic [CW-1:0]      count_q,  count_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0]   rem_q,    rem_d;
    logic [WIDTH-1:0]   dvd_q,    dvd_d;
    logic [WIDTH-1:0]   dsr_q,    dsr_d;
    logic               sgnq_q,   sgnq_d;
    logic               sgnr_q,   sgnr_d;

    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   q_next;
    logic [WIDTH-1:0]   r_next;

    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? (~x + WIDTH'(1)) : x;
    endfunction

    function automatic logic [WIDTH-1:0] sign_fix(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + WIDTH'(1)) : x;
    endfunction

    // The remainder can reach 2*divisor-1 after the shift, so keep one extra bit; diff's MSB is the borrow.
    assign shifted = {rem_q, dvd_q[WIDTH-1]};
    assign diff    = shifted - {1'b0, dsr_q};
    assign fits    = ~diff[WIDTH];
    assign r_next  = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign q_next  = {dvd_q[WIDTH-2:0], fits};

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        result_d = result_q;
        rem_d    = rem_q;
        dvd_d    = dvd_q;
        dsr_d    = dsr_q;
        sgnq_d   = sgnq_q;
        sgnr_d   = sgnr_q;
        if (annul) begin
            state_d  = ST_IDLE;
            count_d  = '0;
            result_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (div_valid) begin
                        count_d = '0;
                        rem_d   = '0;
                        sgnq_d  = signed_div & (opdata1[WIDTH-1] ^ opdata2[WIDTH-1]);
                        sgnr_d  = signed_div & opdata1[WIDTH-1];
                        dsr_d   = signed_div ? abs_val(opdata2) : opdata2;
                        // Divide-by-zero reports the raw dividend as remainder, so keep it unconverted.
                        if (opdata2 == '0) begin
                            dvd_d   = opdata1;
                            state_d = ST_DIVZERO;
                        end else begin
                            dvd_d   = signed_div ? abs_val(opdata1) : opdata1;
                            state_d = ST_ON;
                        end
                    end
                end
                ST_ON: begin
                    rem_d   = r_next;
                    dvd_d   = q_next;
                    count_d = count_q + CW'(1);
                    if (count_q == LAST) begin
                        state_d  = ST_END;
                        result_d = {sign_fix(r_next, sgnr_q), sign_fix(q_next, sgnq_q)};
                    end
                end
                ST_DIVZERO: begin
                    state_d  = ST_END;
                    result_d = {dvd_q, {WIDTH{1'b1}}};
                end
                default: begin
                    if (!div_valid) state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            count_q  <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            result_q <= result_d;
        end
    end

    // Datapath working registers are always loaded before use, so they carry no reset.
    always_ff @(posedge clk) begin
        rem_q  <= rem_d;
        dvd_q  <= dvd_d;
        dsr_q  <= dsr_d;
        sgnq_q <= sgnq_d;
        sgnr_q <= sgnr_d;
    end

    assign result    = result_q;
    assign ready     = (state_q == ST_END);
    assign stall_div = ((state_q == ST_IDLE) & div_valid & ~annul)
                     | (state_q == ST_ON) | (state_q == ST_DIVZERO);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed corner cases plus random operations
// compared against an arithmetic reference model.
module tb_div_unit;

    logic        clk;
    logic        resetn;
    logic        div_valid;
    logic        signed_div;
    logic [31:0] opdata1;
    logic [31:0] opdata2;
    logic        annul;
    logic [63:0] result;
    logic        ready;
    logic        stall_div;

    int total = 0;
    int bad   = 0;

    div_unit #(.WIDTH(32)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .div_valid  (div_valid),
        .signed_div (signed_div),
        .opdata1    (opdata1),
        .opdata2    (opdata2),
        .annul      (annul),
        .result     (result),
        .ready      (ready),
        .stall_div  (stall_div)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // MIPS semantics: truncating division, remainder takes the dividend's sign.
    function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    // Called just after a falling edge with the unit idle; returns just after a falling edge, unit idle.
    task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic s, input int hold);
        logic [63:0] exp;
        int edges;
        int stall_gap;
        exp = ref_div(a, b, s);
        div_valid  = 1'b1;
        signed_div = s;
        opdata1    = a;
        opdata2    = b;
        #1 chk({tag, ".stall_accept"}, 64'(stall_div), 64'd1);
        edges = 0;
        stall_gap = 0;
        while (!ready && edges < 40) begin
            @(negedge clk);
            edges++;
            if (!ready) begin
                if (!stall_div) stall_gap = 1;
                opdata1 = $urandom;
                opdata2 = $urandom;
                signed_div = 1'($urandom);
            end
        end
        chk({tag, ".latency"}, 64'(edges), (b == 32'd0) ? 64'd2 : 64'd33);
        chk({tag, ".stall_gap"}, 64'(stall_gap), 64'd0);
        chk({tag, ".result"}, result, exp);
        chk({tag, ".stall_end"}, 64'(stall_div), 64'd0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            chk({tag, ".hold_ready"}, 64'(ready), 64'd1);
            chk({tag, ".hold_result"}, result, exp);
            chk({tag, ".hold_stall"}, 64'(stall_div), 64'd0);
        end
        div_valid = 1'b0;
        @(negedge clk);
        chk({tag, ".idle_ready"}, 64'(ready), 64'd0);
        chk({tag, ".idle_result"}, result, exp);
    endtask

    initial begin
        logic [31:0] ra, rb;
        logic        rs;
        resetn     = 1'b0;
        div_valid  = 1'b0;
        signed_div = 1'b0;
        opdata1    = '0;
        opdata2    = '0;
        annul      = 1'b0;
        #2;
        chk("reset.result", result, 64'd0);
        chk("reset.ready", 64'(ready), 64'd0);
        chk("reset.stall", 64'(stall_div), 64'd0);
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);

        do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 0);
        chk("divu_100_7.spec", result, {32'd2, 32'd14});
        do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
        do_div("div_7_m2", 32'd7, 32'hFFFF_FFFE, 1'b1, 0);
        do_div("divu_zero", 32'h1234, 32'd0, 1'b0, 0);
        do_div("div_zero_neg", 32'hFFFF_FFFB, 32'd0, 1'b1, 0);
        do_div("div_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
        do_div("divu_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 0);
        do_div("divu_big_dsr", 32'hFFFF_FFFF, 32'h8000_0001, 1'b0, 0);
        do_div("hold_end", 32'd1000, 32'd33, 1'b0, 3);

        // Abort at iteration 10, then restart on the very next cycle.
        div_valid = 1'b1; signed_div = 1'b0; opdata1 = 32'd5000; opdata2 = 32'd9;
        repeat (11) @(negedge clk);
        chk("annul.busy_before", 64'(stall_div), 64'd1);
        annul = 1'b1;
        @(negedge clk);
        chk("annul.ready", 64'(ready), 64'd0);
        chk("annul.result", result, 64'd0);
        annul = 1'b0; div_valid = 1'b0;
        #1 chk("annul.stall", 64'(stall_div), 64'd0);
        do_div("after_annul", 32'd5000, 32'd9, 1'b0, 0);

        // annul together with div_valid in IDLE must not start an operation.
        div_valid = 1'b1; annul = 1'b1; opdata1 = 32'd77; opdata2 = 32'd5;
        #1 chk("annul_idle.stall", 64'(stall_div), 64'd0);
        @(negedge clk);
        div_valid = 1'b0; annul = 1'b0;
        #1 chk("annul_idle.nostart", 64'(stall_div), 64'd0);
        chk("annul_idle.ready", 64'(ready), 64'd0);
        @(negedge clk);

        // Asynchronous reset in the middle of an iteration.
        do_div("pre_reset", 32'd12345, 32'd67, 1'b0, 0);
        div_valid = 1'b1; opdata1 = 32'd999; opdata2 = 32'd4;
        repeat (6) @(negedge clk);
        #2;
        div_valid = 1'b0;
        resetn = 1'b0;
        #1;
        chk("midreset.result", result, 64'd0);
        chk("midreset.ready", 64'(ready), 64'd0);
        chk("midreset.stall", 64'(stall_div), 64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        do_div("post_reset", 32'hFFFF_FF00, 32'd10, 1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom);
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = {28'd0, rb[3:0]};
                2: rb = rs ? 32'hFFFF_FFFF : 32'd1;
                3: ra = 32'h8000_0000;
                default: ;
            endcase
            do_div("random", ra, rb, rs, n % 2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        bad++;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
